eco_y_compactor: RTL and testbench
==================================

# eco_y_compactor

Response compactor placed directly downstream of the ECO gate-level test circuits (5-bit A/B in, 3-bit Y out). It accepts one 3-bit Y result per handshake and folds it into a multiple-input signature register (MISR). It counts accepted vectors and reports a final signature, plus an optional golden-signature match. Pre-ECO and post-ECO netlists are run through identical stimulus, and equivalence is judged on the signatures.

## Interface

**Parameters**
- `SIG_W`, 16, signature width.
- `CNT_W`, 11, vector counter width; covers the 1024-vector exhaustive A/B space plus one.
- `POLY`, 16'hB400, Galois feedback taps (x^16+x^14+x^13+x^11+1).
- `SEED`, 16'hFFFF, signature value loaded on start.

**Ports**
- `clk`, input, 1, rising-edge clock.
- `rst_n`, input, 1, asynchronous active-low reset.
- `start`, input, 1, single-cycle pulse that begins a run.
- `num_vec`, input, CNT_W, vectors to accept in the run; sampled on the start cycle.
- `y_valid`, input, 1, upstream Y valid.
- `y`, input, 3, response from the circuit under test.
- `y_ready`, output, 1, compactor can accept Y.
- `golden`, input, SIG_W, expected final signature; sampled continuously.
- `signature`, output, SIG_W, current MISR value.
- `vec_cnt`, output, CNT_W, vectors accepted this run.
- `busy`, output, 1, high in RUN.
- `done`, output, 1, high in DONE.
- `match`, output, 1, equals `done && (signature == golden)`.

## Operation

- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - `y_ready` = 0.
  - On `start`: `signature` ← SEED, `vec_cnt` ← 0, latch `num_vec`.
  - Next state is RUN, or DONE if `num_vec` == 0.
- **RUN:**
  - `y_ready` = 1.
  - An accept is any cycle with `y_valid && y_ready`.
  - On accept: `signature` ← (sig >> 1) ^ (sig[0] ? POLY : 0) ^ {zero-extend, y}, and `vec_cnt` += 1.
  - An accept with `vec_cnt` == latched `num_vec` − 1 moves to DONE.
- **DONE:**
  - `y_ready` = 0, and `done` is held high.
  - `signature` and `vec_cnt` are frozen.
  - `start` restarts the run exactly as in IDLE.
- **start while in RUN:** ignored. The run completes with its original `num_vec`.
- **y_valid outside RUN:** ignored. No state change.
- **Arithmetic:** `vec_cnt` never wraps, because the run terminates at `num_vec`. Y is XORed into signature bits [2:0].
- **Reset, asserted at any time including mid-run:**
  - State returns to IDLE.
  - `signature` = 0, `vec_cnt` = 0.
  - `y_ready`, `busy`, `done` and `match` = 0.

## Timing

- Signature and count update on the clock edge of the accept cycle. The new value is visible the following cycle.
- `done` rises the cycle after the final accept, or the cycle after `start` when `num_vec` == 0.
- `y_ready` is registered from state. Its drop takes effect the cycle after the final accept; the final accept cycle itself still shows `y_ready` = 1.
- Throughput is one vector per cycle. There is no combinational path from `y_valid` to `y_ready`.
- `match` is combinational from the registered signature and the `golden` input.

## Configuration

- **`ECO_GOLDEN_CMP_EN` defined:** `match` behaves as specified and a comparator is instantiated.
- **`ECO_GOLDEN_CMP_EN` undefined:** `match` is tied to 0, `golden` is unused, and no comparator logic is generated. All other behaviour is identical.

## Structure

- **Shared package `eco_pkg`:**
  - the state enum `eco_cmp_state_t` (IDLE, RUN, DONE);
  - the default POLY and SEED constants;
  - `ECO_Y_W` = 3.
- **Sub-module `eco_misr`:** holds the signature register and the next-state function. Inputs are `clk`, `rst_n`, `load` (with SEED), `en`, `din[2:0]`; output is `sig`.
- **Top level:** holds the FSM, the counter, the `num_vec` latch and the comparator.

## Test plan

- **Reset values:** assert `rst_n` = 0 mid-run → next cycle `signature` = 0, `vec_cnt` = 0, all flags 0, state IDLE.
- **Single vector, Y = 0:** `start` with `num_vec` = 1, accept y = 3'b000 → `signature` = 16'hCBFF, `vec_cnt` = 1, `done` = 1 one cycle after the accept.
- **Single vector, Y = 5:** `start` with `num_vec` = 1, accept y = 3'b101 → `signature` = 16'hCBFA. With `golden` = 16'hCBFA, `match` = 1; with 16'hCBFF, `match` = 0 (or 0 in both cases when `ECO_GOLDEN_CMP_EN` is undefined).
- **Backpressure and restart:**
  - `num_vec` = 2, y = 0 twice, with `y_valid` gapped → `signature` = 16'hD1FF.
  - `y_valid` held after DONE → no change.
  - `start` in DONE → `signature` = 16'hFFFF, `vec_cnt` = 0, `busy` = 1.
- **Zero-vector run:** `num_vec` = 0 → `done` = 1 the cycle after `start`, `signature` = 16'hFFFF, `y_ready` never 1.
- **Exhaustive run:** `num_vec` = 1024, driven by all A/B pairs through a reference circuit → `vec_cnt` = 1024 and `done` = 1. A pre-ECO and a post-ECO netlist produce equal signatures.

Source files
------------

// File: rtl/eco_pkg.sv
// Shared types and constants for the ECO Y-response compactor.
package eco_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } eco_cmp_state_t;

  localparam int          ECO_Y_W   = 3;
  localparam int          ECO_SIG_W = 16;
  localparam int          ECO_CNT_W = 11;
  // Galois taps for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] ECO_POLY  = 16'hB400;
  localparam logic [15:0] ECO_SEED  = 16'hFFFF;

endpackage

// File: rtl/eco_misr.sv
// Galois MISR folding one ECO_Y_W-bit response per enabled cycle; load has priority.
// Latency: new signature visible the cycle after load/en; no backpressure of its own.
module eco_misr
  import eco_pkg::*;
#(
  parameter int               SIG_W = ECO_SIG_W,
  parameter logic [SIG_W-1:0] POLY  = ECO_POLY,
  parameter logic [SIG_W-1:0] SEED  = ECO_SEED
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic [ECO_Y_W-1:0] din,
  output logic [SIG_W-1:0]   sig
);

  logic [SIG_W-1:0] sig_nxt;

  always_comb begin
    sig_nxt = (sig >> 1) ^ (sig[0] ? POLY : '0) ^ {{(SIG_W-ECO_Y_W){1'b0}}, din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= sig_nxt;
    end
  end

endmodule

// File: rtl/eco_y_compactor.sv
// Y-response compactor: counts num_vec accepted vectors into a MISR; y_ready decoded from state, 1 vector/cycle.
// Build option ECO_GOLDEN_CMP_EN enables the golden-signature comparator driving match.
module eco_y_compactor
  import eco_pkg::*;
#(
  parameter int               SIG_W = ECO_SIG_W,
  parameter int               CNT_W = ECO_CNT_W,
  parameter logic [SIG_W-1:0] POLY  = ECO_POLY,
  parameter logic [SIG_W-1:0] SEED  = ECO_SEED
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_vec,
  input  logic               y_valid,
  input  logic [ECO_Y_W-1:0] y,
  output logic               y_ready,
  input  logic [SIG_W-1:0]   golden,
  output logic [SIG_W-1:0]   signature,
  output logic [CNT_W-1:0]   vec_cnt,
  output logic               busy,
  output logic               done,
  output logic               match
);

  localparam logic [1:0]       ST_IDLE = IDLE;
  localparam logic [1:0]       ST_RUN  = RUN;
  localparam logic [1:0]       ST_DONE = DONE;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] num_q;
  logic             accept;
  logic             load;

  assign y_ready = (state == ST_RUN);
  assign busy    = y_ready;
  assign done    = (state == ST_DONE);
  assign vec_cnt = cnt_q;
  assign accept  = y_valid && y_ready;
  // start is only honoured outside RUN so an in-flight run keeps its length
  assign load    = start && (state != ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt_q <= '0;
      num_q <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept) begin
            cnt_q <= cnt_q + CNT_ONE;
            if (cnt_q == num_q - CNT_ONE) begin
              state <= ST_DONE;
            end
          end
        end
        default: begin
          if (start) begin
            cnt_q <= '0;
            num_q <= num_vec;
            state <= (num_vec == '0) ? ST_DONE : ST_RUN;
          end
        end
      endcase
    end
  end

  eco_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .en    (accept),
    .din   (y),
    .sig   (signature)
  );

`ifdef ECO_GOLDEN_CMP_EN
  assign match = done && (signature == golden);
`else
  logic unused_golden;
  assign unused_golden = ^golden;
  assign match         = 1'b0;
`endif

endmodule

// File: tb/tb_eco_y_compactor.sv
// Randomized scoreboard bench for eco_y_compactor against a plain-arithmetic MISR model.
module tb_eco_y_compactor;

`ifdef ECO_GOLDEN_CMP_EN
  localparam bit MATCH_EN = 1'b1;
`else
  localparam bit MATCH_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] sig;
    int          cnt;
    bit          m;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] num_vec;
  logic        y_valid;
  logic [2:0]  y;
  logic        y_ready;
  logic [15:0] golden;
  logic [15:0] signature;
  logic [10:0] vec_cnt;
  logic        busy;
  logic        done;
  logic        match;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  logic [2:0]  ys_q[$];

  always #5 clk = ~clk;

  eco_y_compactor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_vec   (num_vec),
    .y_valid   (y_valid),
    .y         (y),
    .y_ready   (y_ready),
    .golden    (golden),
    .signature (signature),
    .vec_cnt   (vec_cnt),
    .busy      (busy),
    .done      (done),
    .match     (match)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Signature after folding every response in ys_q into the seeded register.
  function automatic logic [15:0] misr_model();
    logic [15:0] s = 16'hFFFF;
    foreach (ys_q[i]) begin
      if (s % 2 == 1) s = (s / 2) ^ 16'hB400;
      else            s = s / 2;
      s = s ^ {13'd0, ys_q[i]};
    end
    return s;
  endfunction

  // Offer one response (called at a negedge); returns at the negedge after acceptance.
  task automatic push_y(input logic [2:0] v);
    int guard = 0;
    y_valid = 1'b1;
    y       = v;
    while (!y_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("y_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    y_valid = 1'b0;
  endtask

  task automatic do_run(input int n, input bit gapped, input bit gold_ok, input bit poke_start);
    exp_t        e;
    logic [15:0] es;
    es    = misr_model();
    e.sig = es;
    e.cnt = n;
    e.m   = MATCH_EN && gold_ok;
    exp_q.push_back(e);
    golden = gold_ok ? es : ~es;
    @(negedge clk);
    start   = 1'b1;
    num_vec = 11'(n);
    @(negedge clk);
    start   = 1'b0;
    chk("start_sig", 32'(signature), 32'hFFFF);
    chk("start_cnt", 32'(vec_cnt), 32'd0);
    chk("start_busy", 32'(busy), 32'(n != 0));
    if (n == 0) begin
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_ready", 32'(y_ready), 32'd0);
    end
    for (int i = 0; i < n; i++) begin
      if (gapped) repeat ($urandom_range(0, 3)) @(negedge clk);
      push_y(ys_q[i]);
      chk("done_timing", 32'(done), 32'(i == n - 1));
      if (poke_start && i == 0 && n >= 2) begin
        start   = 1'b1;
        num_vec = 11'($urandom_range(1, 50));
        @(negedge clk);
        start   = 1'b0;
        chk("start_in_run_busy", 32'(busy), 32'd1);
      end
    end
  endtask

  // Monitor: on each rising done, compare against the oldest expected run.
  initial begin
    logic done_prev = 1'b0;
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("mon_sig", 32'(signature), 32'(e.sig));
          chk("mon_cnt", 32'(vec_cnt), 32'(e.cnt));
          chk("mon_match", 32'(match), 32'(e.m));
          chk("mon_ready", 32'(y_ready), 32'd0);
        end
      end
      done_prev = done;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sig_pre;
    int          n;
    int          zr;
    rst_n   = 1'b0;
    start   = 1'b0;
    num_vec = '0;
    y_valid = 1'b0;
    y       = '0;
    golden  = '0;
    repeat (3) @(negedge clk);
    chk("rst_sig", 32'(signature), 32'd0);
    chk("rst_cnt", 32'(vec_cnt), 32'd0);
    chk("rst_flags", {28'd0, y_ready, busy, done, match}, 32'd0);
    rst_n = 1'b1;

    // y_valid in IDLE must not disturb anything
    y_valid = 1'b1;
    y       = 3'd7;
    repeat (3) @(negedge clk);
    y_valid = 1'b0;
    chk("idle_valid_sig", 32'(signature), 32'd0);
    chk("idle_valid_cnt", 32'(vec_cnt), 32'd0);

    // zero-vector run
    ys_q.delete();
    do_run(0, 1'b0, 1'b1, 1'b0);
    zr = 0;
    repeat (4) begin
      @(negedge clk);
      zr |= int'(y_ready);
    end
    chk("zero_ready_never", 32'(zr), 32'd0);
    chk("zero_sig", 32'(signature), 32'hFFFF);

    ys_q = '{3'd0};
    do_run(1, 1'b0, 1'b1, 1'b0);
    chk("y0_sig", 32'(signature), 32'hCBFF);
    chk("y0_cnt", 32'(vec_cnt), 32'd1);

    ys_q = '{3'd5};
    do_run(1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("y5_sig", 32'(signature), 32'hCBFA);
    golden = 16'hCBFA;
    #1 chk("y5_match_hit", 32'(match), 32'(MATCH_EN));
    golden = 16'hCBFF;
    #1 chk("y5_match_miss", 32'(match), 32'd0);

    ys_q = '{3'd0, 3'd0};
    do_run(2, 1'b1, 1'b1, 1'b0);
    chk("gap2_sig", 32'(signature), 32'hD1FF);
    y_valid = 1'b1;
    y       = 3'd6;
    repeat (4) @(negedge clk);
    y_valid = 1'b0;
    chk("hold_sig", 32'(signature), 32'hD1FF);
    chk("hold_cnt", 32'(vec_cnt), 32'd2);
    chk("hold_ready", 32'(y_ready), 32'd0);
    chk("hold_done", 32'(done), 32'd1);

    // randomized runs, restarting from DONE, some poking start mid-run
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(1, 24);
      ys_q.delete();
      for (int i = 0; i < n; i++) ys_q.push_back(3'($urandom_range(0, 7)));
      do_run(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // reset in the middle of a run
    @(negedge clk);
    start   = 1'b1;
    num_vec = 11'd8;
    @(negedge clk);
    start   = 1'b0;
    for (int i = 0; i < 3; i++) push_y(3'($urandom_range(0, 7)));
    rst_n = 1'b0;
    #1;
    chk("midrst_sig", 32'(signature), 32'd0);
    chk("midrst_cnt", 32'(vec_cnt), 32'd0);
    chk("midrst_flags", {28'd0, y_ready, busy, done, match}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle", {29'd0, y_ready, busy, done}, 32'd0);

    // exhaustive A/B space through two equivalent formulations of a 3-bit adder
    ys_q.delete();
    for (int a = 0; a < 32; a++)
      for (int b = 0; b < 32; b++) ys_q.push_back(3'((a + b) % 8));
    do_run(1024, 1'b0, 1'b1, 1'b0);
    chk("exh_pre_cnt", 32'(vec_cnt), 32'd1024);
    chk("exh_pre_done", 32'(done), 32'd1);
    sig_pre = signature;
    ys_q.delete();
    for (int a = 0; a < 32; a++)
      for (int b = 0; b < 32; b++) ys_q.push_back(3'(a) + 3'(b));
    do_run(1024, 1'b0, 1'b1, 1'b0);
    chk("exh_post_cnt", 32'(vec_cnt), 32'd1024);
    chk("exh_equiv", 32'(signature), 32'(sig_pre));

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
